display_timing_480p: RTL and testbench

- Pixel-domain consumer of the 25.2 MHz pixel clock and its synchronized lock flag from the 480p clock generator.
- Holds the display idle until the clock has been stably locked for a programmable settle time, then produces 640x480 @ 60 Hz VGA timing.
- Timing outputs: hsync, vsync, data-enable, screen coordinates and frame/line strobes, consumed by downstream pixel/SerDes logic.
- Returns to idle whenever lock is lost.

---
 rtl/display_480p_pkg.sv | 46 ++++
 rtl/display_bar_pattern.sv | 42 ++++
 rtl/display_timing_480p.sv | 192 +++++++++++++++++++
 tb/tb_display_timing_480p.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_480p_pkg.sv
// display_480p_pkg: shared constants for the 640x480 @ 60 Hz timing block.
//   - Default VGA timing numbers and the derived totals and sync windows.
//   - Settle FSM state encoding.
//   - Colour-bar lookup used by the optional test pattern.
//     The pattern is built only when DISPLAY_TEST_PATTERN_EN is defined.
package display_480p_pkg;

    localparam int unsigned VGA_CORDW    = 10;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam bit          VGA_SYNC_POL = 1'b0;
    localparam int unsigned VGA_SETTLE_CYCLES = 1024;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    typedef enum logic [1:0] {
        StWait   = 2'd0,
        StSettle = 2'd1,
        StRun    = 2'd2
    } state_e;

    // Colour bars, {r, g, b} at 2 bits each, indexed left to right across the line.
    localparam int unsigned VGA_BAR_WIDTH = 80;
    localparam logic [7:0][5:0] VGA_BAR_RGB = {
        6'b00_00_00,  // 7 black
        6'b00_00_11,  // 6 blue
        6'b11_00_00,  // 5 red
        6'b11_00_11,  // 4 magenta
        6'b00_11_00,  // 3 green
        6'b00_11_11,  // 2 cyan
        6'b11_11_00,  // 1 yellow
        6'b11_11_11   // 0 white
    };

endpackage

// File: rtl/display_bar_pattern.sv
// display_bar_pattern: registered 8-bar colour pattern for the active area.
// It is instantiated only when DISPLAY_TEST_PATTERN_EN is defined.
// Ports:
//   clk_i  - pixel clock.
//   rst_ni - asynchronous active-low reset.
//   hc_i   - raw horizontal counter.
//   de_i   - unregistered data enable for hc_i.
//   rgb_o  - {r, g, b} at 2 bits each.
//            It is registered and so aligned with the registered de.
//            It is zero while de is low.
module display_bar_pattern
    import display_480p_pkg::*;
#(
    parameter int unsigned CORDW = VGA_CORDW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CORDW-1:0] hc_i,
    input  logic             de_i,
    output logic [5:0]       rgb_o
);

    logic [2:0] bar_idx;
    logic [5:0] rgb_d, rgb_q;

    always_comb begin
        // hc < H_ACTIVE whenever de_i is set, so the quotient always fits in 3 bits.
        bar_idx = 3'(hc_i / CORDW'(VGA_BAR_WIDTH));
        rgb_d   = de_i ? VGA_BAR_RGB[bar_idx] : 6'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q <= 6'b0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/display_timing_480p.sv
// display_timing_480p: 640x480 @ 60 Hz VGA timing generator in the pixel clock domain.
// It waits for clk_pix_locked to stay high for SETTLE_CYCLES consecutive cycles.
// It then runs the raster counters.
// Any lock loss drops it back to idle.
// Ports:
//   clk_pix        - pixel clock.
//   rst_n          - asynchronous active-low reset.
//   clk_pix_locked - lock flag, already synchronous to clk_pix.
//   running        - high while timing is being generated.
//   hsync, vsync   - sync outputs; SYNC_POL gives the active level.
//   de             - data enable, high in the active area.
//   sx, sy         - screen position.
//   frame          - strobe at position (0,0).
//   line           - strobe at sx == 0.
//   vga_r/g/b      - colour-bar test pattern.
//                    These ports exist only when DISPLAY_TEST_PATTERN_EN is defined.
// All outputs are registered, one cycle behind the raw counters, and mutually aligned.
module display_timing_480p
    import display_480p_pkg::*;
#(
    parameter int unsigned CORDW         = VGA_CORDW,
    parameter int unsigned H_ACTIVE      = VGA_H_ACTIVE,
    parameter int unsigned H_FP          = VGA_H_FP,
    parameter int unsigned H_SYNC        = VGA_H_SYNC,
    parameter int unsigned H_BP          = VGA_H_BP,
    parameter int unsigned V_ACTIVE      = VGA_V_ACTIVE,
    parameter int unsigned V_FP          = VGA_V_FP,
    parameter int unsigned V_SYNC        = VGA_V_SYNC,
    parameter int unsigned V_BP          = VGA_V_BP,
    parameter bit          SYNC_POL      = VGA_SYNC_POL,
    parameter int unsigned SETTLE_CYCLES = VGA_SETTLE_CYCLES
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             clk_pix_locked,
    output logic             running,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             frame,
    output logic             line
`ifdef DISPLAY_TEST_PATTERN_EN
    ,
    output logic [1:0]       vga_r,
    output logic [1:0]       vga_g,
    output logic [1:0]       vga_b
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] HMax   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] VMax   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] HAct   = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] VAct   = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] HsStart = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] HsEnd   = CORDW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VsStart = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] VsEnd   = CORDW'(V_ACTIVE + V_FP + V_SYNC);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SettleMax = SW'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CORDW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic             in_run;
    logic             de_d, hsync_d, vsync_d, frame_d, line_d;
    logic             running_q, hsync_q, vsync_q, de_q, frame_q, line_q;
    logic [CORDW-1:0] sx_q, sy_q;

    // Settle FSM.
    // The counter holds how many consecutive locked edges have been seen.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            StWait: begin
                if (clk_pix_locked) begin
                    state_d  = StSettle;
                    settle_d = SW'(1);
                end
            end
            StSettle: begin
                if (!clk_pix_locked) begin
                    state_d  = StWait;
                    settle_d = '0;
                end else if (settle_q == SettleMax) begin
                    state_d  = StRun;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StRun: begin
                if (!clk_pix_locked) state_d = StWait;
            end
            default: begin
                state_d  = StWait;
                settle_d = '0;
            end
        endcase
    end

    // Raw raster counters.
    // They are held at zero outside RUN, so the first RUN cycle starts at (0,0).
    always_comb begin
        hc_d = '0;
        vc_d = '0;
        if (state_q == StRun && clk_pix_locked) begin
            vc_d = vc_q;
            if (hc_q == HMax) begin
                hc_d = '0;
                vc_d = (vc_q == VMax) ? '0 : vc_q + CORDW'(1);
            end else begin
                hc_d = hc_q + CORDW'(1);
            end
        end
    end

    // Output decode.
    // Counters are zero outside RUN, so strobes must also be gated by in_run.
    always_comb begin
        in_run  = (state_q == StRun);
        de_d    = in_run && (hc_q < HAct) && (vc_q < VAct);
        hsync_d = (in_run && hc_q >= HsStart && hc_q < HsEnd) ? SYNC_POL : ~SYNC_POL;
        vsync_d = (in_run && vc_q >= VsStart && vc_q < VsEnd) ? SYNC_POL : ~SYNC_POL;
        frame_d = in_run && (hc_q == '0) && (vc_q == '0);
        line_d  = in_run && (hc_q == '0);
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StWait;
            settle_q  <= '0;
            hc_q      <= '0;
            vc_q      <= '0;
            running_q <= 1'b0;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            de_q      <= 1'b0;
            sx_q      <= '0;
            sy_q      <= '0;
            frame_q   <= 1'b0;
            line_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            running_q <= in_run;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            sx_q      <= hc_q;
            sy_q      <= vc_q;
            frame_q   <= frame_d;
            line_q    <= line_d;
        end
    end

    assign running = running_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign de      = de_q;
    assign sx      = sx_q;
    assign sy      = sy_q;
    assign frame   = frame_q;
    assign line    = line_q;

`ifdef DISPLAY_TEST_PATTERN_EN
    logic [5:0] rgb;

    display_bar_pattern #(
        .CORDW (CORDW)
    ) u_bar_pattern (
        .clk_i  (clk_pix),
        .rst_ni (rst_n),
        .hc_i   (hc_q),
        .de_i   (de_d),
        .rgb_o  (rgb)
    );

    assign vga_r = rgb[5:4];
    assign vga_g = rgb[3:2];
    assign vga_b = rgb[1:0];
`endif

endmodule

// File: tb/tb_display_timing_480p.sv
// Testbench for display_timing_480p.
// Horizontal timing is the real 800-pixel line.
// The vertical timing is shortened to a 13-line frame (6 active + 2 FP + 2 sync + 3 BP).
// This keeps the run short.
// Settle time is 16 cycles.
// Reference model: a count of consecutive locked edges.
// Running starts SETTLE+1 locked edges in.
// From then the pixel index n gives hc = n % 800 and vc = (n / 800) % 13.
module tb_display_timing_480p;

    localparam int SETTLE = 16;
    localparam int HT     = 800;
    localparam int VA     = 6;
    localparam int VFP    = 2;
    localparam int VS     = 2;
    localparam int VB     = 3;
    localparam int VT     = VA + VFP + VS + VB;

    logic       clk_pix = 1'b0;
    logic       rst_n   = 1'b0;
    logic       lock    = 1'b0;
    logic       running, hsync, vsync, de, frame, line;
    logic [9:0] sx, sy;
`ifdef DISPLAY_TEST_PATTERN_EN
    logic [1:0] vga_r, vga_g, vga_b;
`endif

    always #5 clk_pix = ~clk_pix;

    display_timing_480p #(
        .V_ACTIVE      (VA),
        .V_FP          (VFP),
        .V_SYNC        (VS),
        .V_BP          (VB),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk_pix        (clk_pix),
        .rst_n          (rst_n),
        .clk_pix_locked (lock),
        .running        (running),
        .hsync          (hsync),
        .vsync          (vsync),
        .de             (de),
        .sx             (sx),
        .sy             (sy),
        .frame          (frame),
        .line           (line)
`ifdef DISPLAY_TEST_PATTERN_EN
        ,
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

`ifdef DISPLAY_TEST_PATTERN_EN
    function automatic logic [5:0] bar_colour(input int x);
        logic [5:0] tbl [8];
        tbl = '{6'b111111, 6'b111100, 6'b001111, 6'b001100,
                6'b110011, 6'b110000, 6'b000011, 6'b000000};
        return tbl[x / 80];
    endfunction
`endif

    // Consecutive locked edge counts.
    // pstreak lags by one edge because the outputs are registered.
    int streak, pstreak;
    always @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            streak  <= 0;
            pstreak <= 0;
        end else begin
            pstreak <= streak;
            streak  <= lock ? streak + 1 : 0;
        end
    end

    // Per-cycle comparison against the model.
    int printed = 0;
    always @(negedge clk_pix) begin : cmp
        int   n, ehc, evc;
        logic er, eh, ev, ed, ef, el;
        logic [5:0] ergb, argb;
        er = 0; eh = 1; ev = 1; ed = 0; ef = 0; el = 0; ehc = 0; evc = 0;
        if (pstreak >= SETTLE + 1) begin
            n   = pstreak - (SETTLE + 1);
            ehc = n % HT;
            evc = (n / HT) % VT;
            er  = 1;
            ed  = (ehc < 640) && (evc < VA);
            eh  = !(ehc >= 656 && ehc < 752);
            ev  = !(evc >= VA + VFP && evc < VA + VFP + VS);
            ef  = (ehc == 0) && (evc == 0);
            el  = (ehc == 0);
        end
        ergb = 6'b0;
        argb = 6'b0;
`ifdef DISPLAY_TEST_PATTERN_EN
        ergb = ed ? bar_colour(ehc) : 6'b0;
        argb = {vga_r, vga_g, vga_b};
`endif
        tests++;
        if ({running, hsync, vsync, de, frame, line, sx, sy, argb} !==
            {er, eh, ev, ed, ef, el, 10'(ehc), 10'(evc), ergb}) begin
            fails++;
            if (printed < 10) begin
                printed++;
                $display("FAIL model t=%0t: got run=%b hs=%b vs=%b de=%b fr=%b ln=%b sx=%0d sy=%0d rgb=%b, expected run=%b hs=%b vs=%b de=%b fr=%b ln=%b sx=%0d sy=%0d rgb=%b",
                         $time, running, hsync, vsync, de, frame, line, sx, sy, argb,
                         er, eh, ev, ed, ef, el, ehc, evc, ergb);
            end
        end
    end

    // Edges from the first locked edge (index 0) until running is seen; -1 on timeout.
    task automatic measure_rise(output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_pix);
            @(negedge clk_pix);
            if (running) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_xy(input int x, input int y, input int bound, output logic ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_pix);
            if (sx == 10'(x) && (y < 0 || sy == 10'(y))) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        int   lat, de_n, hs_n, hs_first, next_line;
        int   f_at[3], nf, fde, vs_n, vs_first;
        logic ok;

        // Reset with lock already high.
        lock  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_pix);
        check("reset_running", running, 0);
        check("reset_hsync", hsync, 1);
        check("reset_vsync", vsync, 1);
        check("reset_de", de, 0);
        check("reset_sx", sx, 0);
        check("reset_sy", sy, 0);

        // Release the reset; the next posedge is the first locked edge.
        rst_n = 1'b1;
        measure_rise(lat);
        check("first_rise_latency", lat, 17);
        check("first_frame_strobe", frame, 1);
        check("first_sx", sx, 0);
        check("first_sy", sy, 0);

        // One line, starting at sx=0.
        de_n = 0; hs_n = 0; hs_first = -1; next_line = -1;
        for (int i = 0; i < 900; i++) begin
            if (i > 0 && line && next_line < 0) next_line = i;
            if (i < HT) begin
                if (de) de_n++;
                if (!hsync) begin
                    hs_n++;
                    if (hs_first < 0) hs_first = int'(sx);
                end
            end
            @(negedge clk_pix);
        end
        check("line_de_count", de_n, 640);
        check("line_hsync_count", hs_n, 96);
        check("line_hsync_start", hs_first, 656);
        check("line_period", next_line, HT);

        // Two frames, measured from a frame strobe.
        ok = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            @(negedge clk_pix);
            if (frame) begin
                ok = 1;
                break;
            end
        end
        check("frame_found", ok, 1);
        nf = 0; fde = 0; vs_n = 0; vs_first = -1;
        for (int i = 0; i <= 2 * HT * VT; i++) begin
            if (frame && nf < 3) begin
                f_at[nf] = i;
                nf++;
            end
            if (i < HT * VT) begin
                if (de) fde++;
                if (!vsync) begin
                    vs_n++;
                    if (vs_first < 0) vs_first = int'(sy);
                end
            end
            if (i < 2 * HT * VT) @(negedge clk_pix);
        end
        check("frame_strobes", nf, 3);
        check("frame_period_1", f_at[1] - f_at[0], 10400);
        check("frame_period_2", f_at[2] - f_at[1], 10400);
        check("frame_de_count", fde, 3840);
        check("frame_vsync_count", vs_n, 1600);
        check("frame_vsync_first_line", vs_first, 8);

        // Lock loss mid-frame.
        wait_xy(300, 4, 2 * HT * VT, ok);
        check("loss_point_found", ok, 1);
        lock = 1'b0;
        @(negedge clk_pix);
        @(negedge clk_pix);
        check("loss_running", running, 0);
        check("loss_idle", {hsync, vsync, de, frame, line}, 5'b11000);
        check("loss_sx", sx, 0);
        check("loss_sy", sy, 0);
        lock = 1'b1;
        measure_rise(lat);
        check("relock_latency", lat, 17);
        check("relock_origin", {frame, line, sx, sy}, {2'b11, 20'd0});

`ifdef DISPLAY_TEST_PATTERN_EN
        check("rgb_sx0", {vga_r, vga_g, vga_b}, 6'b111111);
        wait_xy(360, 0, HT, ok);
        check("rgb_sx360", {ok, vga_r, vga_g, vga_b}, 7'b1_110011);
        wait_xy(400, 0, HT, ok);
        check("rgb_sx400", {ok, vga_r, vga_g, vga_b}, 7'b1_110000);
        wait_xy(700, 0, HT, ok);
        check("rgb_sx700", {ok, de, vga_r, vga_g, vga_b}, 8'b1_0_000000);
`endif

        // A settle glitch at count 10 restarts the full settle.
        lock = 1'b0;
        repeat (4) @(negedge clk_pix);
        check("glitch_pre_idle", running, 0);
        lock = 1'b1;
        repeat (10) @(posedge clk_pix);
        @(negedge clk_pix);
        lock = 1'b0;
        @(negedge clk_pix);
        check("glitch_not_running", running, 0);
        lock = 1'b1;
        measure_rise(lat);
        check("glitch_relock_latency", lat, 17);

        // Asynchronous reset while running.
        repeat (50) @(negedge clk_pix);
        rst_n = 1'b0;
        #1;
        check("async_reset_running", running, 0);
        check("async_reset_de", de, 0);
        repeat (2) @(negedge clk_pix);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
